// File: rtl/gray_fetch_ctrl_if.sv
// Handshake, memory and window bundle for gray_fetch_ctrl.
// master drives requests, read data and acks; slave is the controller.
interface gray_fetch_ctrl_if;
  logic        gray_ready;
  logic        fetch_req;
  logic [13:0] lbp_addr;
  logic        fill_right;
  logic        fill_left;
  logic        fill_down;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic [7:0]  gray_data;
  logic [71:0] win;
  logic        win_valid;
  logic        win_ack;
  logic        busy;
  logic        done;

  modport master (
    output gray_ready, fetch_req, lbp_addr,
    output fill_right, fill_left, fill_down,
    output gray_data, win_ack,
    input  gray_req, gray_addr, win,
    input  win_valid, busy, done
  );

  modport slave (
    input  gray_ready, fetch_req, lbp_addr,
    input  fill_right, fill_left, fill_down,
    input  gray_data, win_ack,
    output gray_req, gray_addr, win,
    output win_valid, busy, done
  );
endinterface

// File: rtl/gray_fetch_ctrl.sv
// 3x3 window fetch controller over a 128x128 gray image.
// Define GFC_RDCNT_EN to add the saturating rd_cnt read counter port.
module gray_fetch_ctrl (
  input  logic clk,
  input  logic reset,
`ifdef GFC_RDCNT_EN
  output logic [17:0] rd_cnt,
`endif
  gray_fetch_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, FULL, PART, DRAIN, VALID
  } state_t;

  typedef enum logic [1:0] {
    M_FULL, M_RIGHT, M_LEFT, M_DOWN
  } mode_t;

  state_t state, state_nx;
  mode_t  mode, mode_sel;
  logic   first_flag;
  logic   accept;
  logic   last;
  logic   cap_pend;
  logic [3:0] cnt;
  logic [3:0] cap_slot;
  logic [6:0] row;
  logic [6:0] col;
  logic [0:8][7:0] pix;

  function automatic logic [13:0] rd_addr(
    input mode_t m,
    input logic [6:0] r,
    input logic [6:0] c,
    input logic [3:0] k
  );
    logic [1:0] ro;
    logic [6:0] rr, cc, kk, co;
    ro = (k >= 4'd6) ? 2'd2 :
         (k >= 4'd3) ? 2'd1 : 2'd0;
    kk = 7'(k);
    co = 7'(k - 4'd3 * {2'b00, ro});
    case (m)
      M_RIGHT: begin
        rr = r + kk - 7'd1;
        cc = c + 7'd1;
      end
      M_LEFT: begin
        rr = r + kk - 7'd1;
        cc = c - 7'd1;
      end
      M_DOWN: begin
        rr = r + 7'd1;
        cc = c + kk - 7'd1;
      end
      default: begin
        rr = r + 7'(ro) - 7'd1;
        cc = c + co - 7'd1;
      end
    endcase
    return {rr, cc};
  endfunction

  function automatic logic [3:0] slot_of(
    input mode_t m,
    input logic [3:0] k
  );
    case (m)
      M_RIGHT: return 4'd3 * k + 4'd2;
      M_LEFT:  return 4'd3 * k;
      M_DOWN:  return 4'd6 + k;
      default: return k;
    endcase
  endfunction

  // Keep the overlapping columns/rows; the vacated ones are refilled.
  function automatic logic [0:8][7:0] shift_win(
    input logic [0:8][7:0] p,
    input mode_t m
  );
    logic [0:8][7:0] s;
    s = p;
    case (m)
      M_RIGHT: begin
        s[0] = p[1]; s[1] = p[2];
        s[3] = p[4]; s[4] = p[5];
        s[6] = p[7]; s[7] = p[8];
      end
      M_LEFT: begin
        s[1] = p[0]; s[2] = p[1];
        s[4] = p[3]; s[5] = p[4];
        s[7] = p[6]; s[8] = p[7];
      end
      M_DOWN:  s[0:5] = p[3:8];
      default: s = p;
    endcase
    return s;
  endfunction

  always_comb begin
    if (first_flag || !(bus.fill_right ||
        bus.fill_left || bus.fill_down))
      mode_sel = M_FULL;
    else if (bus.fill_right)
      mode_sel = M_RIGHT;
    else if (bus.fill_left)
      mode_sel = M_LEFT;
    else
      mode_sel = M_DOWN;
  end

  assign accept = (state == IDLE) &&
                  bus.fetch_req && bus.gray_ready;
  assign last = (mode == M_FULL) ? (cnt == 4'd8)
                                 : (cnt == 4'd2);
  assign bus.win = pix;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.gray_req  = 1'b0;
    bus.busy      = 1'b1;
    bus.win_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (accept)
          state_nx = (mode_sel == M_FULL) ? FULL : PART;
      end
      FULL, PART: begin
        bus.gray_req = 1'b1;
        if (last) state_nx = DRAIN;
      end
      DRAIN: state_nx = VALID;
      VALID: begin
        bus.win_valid = 1'b1;
        if (bus.win_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode          <= M_FULL;
      row           <= '0;
      col           <= '0;
      cnt           <= '0;
      cap_pend      <= 1'b0;
      cap_slot      <= '0;
      pix           <= '0;
      first_flag    <= 1'b1;
      bus.gray_addr <= '0;
      bus.done      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      cap_pend <= bus.gray_req;
      cap_slot <= slot_of(mode, cnt);
      if (accept) begin
        mode <= mode_sel;
        row  <= bus.lbp_addr[13:7];
        col  <= bus.lbp_addr[6:0];
        cnt  <= '0;
        pix  <= shift_win(pix, mode_sel);
        bus.gray_addr <= rd_addr(mode_sel,
          bus.lbp_addr[13:7], bus.lbp_addr[6:0], 4'd0);
      end else begin
        if (cap_pend) pix[cap_slot] <= bus.gray_data;
        if (bus.gray_req && !last) begin
          cnt <= cnt + 4'd1;
          bus.gray_addr <= rd_addr(mode, row, col,
                                   cnt + 4'd1);
        end
      end
      if (bus.win_valid && bus.win_ack) begin
        first_flag <= 1'b0;
        bus.done   <= ({row, col} == 14'h3F01);
      end
    end
  end

`ifdef GFC_RDCNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      rd_cnt <= '0;
    else if (bus.gray_req && rd_cnt != 18'h3FFFF)
      rd_cnt <= rd_cnt + 18'd1;
  end
`endif

endmodule

// File: tb/tb_gray_fetch_ctrl.sv
// Scoreboard bench for gray_fetch_ctrl: random image, random moves,
// expected reads and windows derived from image coordinates.
module tb_gray_fetch_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gray_fetch_ctrl_if bus ();

`ifdef GFC_RDCNT_EN
  logic [17:0] rd_cnt;
`endif

  gray_fetch_ctrl dut (
    .clk(clk),
    .reset(reset),
`ifdef GFC_RDCNT_EN
    .rd_cnt(rd_cnt),
`endif
    .bus(bus)
  );

  typedef struct {
    logic [13:0] addr;
    int          cyc;
  } rd_t;

  typedef struct {
    logic [71:0] win;
    int          cyc;
    logic [13:0] ctr;
  } wn_t;

  logic [7:0] mem [16384];
  rd_t rdq[$];
  wn_t wq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int reads_model = 0;
  bit mfirst = 1'b1;
  bit prev_valid = 1'b0;
  bit exp_done = 1'b0;
  logic [13:0] cur_ctr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory answers one cycle after the strobe; garbage otherwise.
  always @(posedge clk)
    bus.gray_data <= bus.gray_req ? mem[bus.gray_addr]
                                  : 8'($urandom);

  task automatic chk(input string nm,
                     input logic [71:0] act,
                     input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] a(input int r, input int c);
    return 14'(r * 128 + c);
  endfunction

  function automatic logic [71:0] exp_win(input int r,
                                          input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[71 - 8 * (3 * i + j) -: 8] =
          mem[(r - 1 + i) * 128 + (c - 1 + j)];
    return w;
  endfunction

  // Present a request and record what the design must do with it.
  task automatic issue(input int r, input int c,
                       input bit fr, input bit fl,
                       input bit fd);
    int m, n, acc;
    rd_t e;
    wn_t w;
    m = (mfirst || !(fr || fl || fd)) ? 0 :
        fr ? 1 : fl ? 2 : 3;
    n = (m == 0) ? 9 : 3;
    acc = cyc;
    bus.lbp_addr   = a(r, c);
    bus.fill_right = fr;
    bus.fill_left  = fl;
    bus.fill_down  = fd;
    bus.fetch_req  = 1'b1;
    for (int k = 0; k < n; k++) begin
      case (m)
        0: e.addr = a(r - 1 + k / 3, c - 1 + k % 3);
        1: e.addr = a(r - 1 + k, c + 1);
        2: e.addr = a(r - 1 + k, c - 1);
        default: e.addr = a(r + 1, c - 1 + k);
      endcase
      e.cyc = acc + 1 + k;
      rdq.push_back(e);
    end
    reads_model += n;
    w.win = exp_win(r, c);
    w.cyc = acc + ((m == 0) ? 11 : 5);
    w.ctr = a(r, c);
    wq.push_back(w);
  endtask

  task automatic fetch(input int r, input int c,
                       input bit fr, input bit fl,
                       input bit fd, input bit ireq,
                       input bit areq);
    int n, h;
    issue(r, c, fr, fl, fd);
    tick();
    bus.fetch_req  = ireq;
    bus.lbp_addr   = 14'($urandom);
    bus.fill_right = 1'($urandom_range(0, 1));
    bus.fill_left  = 1'($urandom_range(0, 1));
    bus.fill_down  = 1'($urandom_range(0, 1));
    if (ireq) begin
      tick();
      tick();
      bus.fetch_req = 1'b0;
    end
    n = 0;
    while (!bus.win_valid && n < 20) begin
      tick();
      n++;
    end
    chk("win_valid_wait", 72'(bus.win_valid), 72'(1));
    h = $urandom_range(0, 3);
    repeat (h) tick();
    bus.win_ack   = 1'b1;
    bus.fetch_req = areq;
    tick();
    bus.win_ack   = 1'b0;
    bus.fetch_req = 1'b0;
    mfirst = 1'b0;
  endtask

  always @(negedge clk) begin
    rd_t e;
    wn_t w;
    if (reset) begin
      prev_valid = 1'b0;
      exp_done   = 1'b0;
    end else begin
      if (bus.gray_req) begin
        if (rdq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read actual=%0h required=none",
                   bus.gray_addr);
        end else begin
          e = rdq.pop_front();
          chk("read_addr", 72'(bus.gray_addr), 72'(e.addr));
          chk("read_cycle", 72'(cyc), 72'(e.cyc));
        end
      end
      if (bus.win_valid && !prev_valid) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_window actual=%0h required=none",
                   bus.win);
        end else begin
          w = wq.pop_front();
          chk("window", bus.win, w.win);
          chk("window_cycle", 72'(cyc), 72'(w.cyc));
          cur_ctr = w.ctr;
        end
      end
      if (bus.done || exp_done)
        chk("done", 72'(bus.done), 72'(exp_done));
      exp_done = bus.win_valid && bus.win_ack &&
                 cur_ctr == 14'h3F01;
      prev_valid = bus.win_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int cr, cc, mv;
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    bus.gray_ready = 1'b1;
    bus.fetch_req  = 1'b0;
    bus.lbp_addr   = '0;
    bus.fill_right = 1'b0;
    bus.fill_left  = 1'b0;
    bus.fill_down  = 1'b0;
    bus.win_ack    = 1'b0;
    repeat (3) tick();
    chk("rst_win", bus.win, 72'(0));
    chk("rst_win_valid", 72'(bus.win_valid), 72'(0));
    chk("rst_busy", 72'(bus.busy), 72'(0));
    chk("rst_done", 72'(bus.done), 72'(0));
    chk("rst_gray_req", 72'(bus.gray_req), 72'(0));
    chk("rst_gray_addr", 72'(bus.gray_addr), 72'(0));
`ifdef GFC_RDCNT_EN
    chk("rst_rd_cnt", 72'(rd_cnt), 72'(0));
`endif
    reset = 1'b0;
    tick();

    bus.win_ack = 1'b1;
    tick();
    bus.win_ack = 1'b0;
    tick();
    chk("ack_idle_busy", 72'(bus.busy), 72'(0));

    bus.gray_ready = 1'b0;
    bus.fetch_req  = 1'b1;
    repeat (3) begin
      tick();
      chk("not_ready_busy", 72'(bus.busy), 72'(0));
    end
    bus.fetch_req  = 1'b0;
    bus.gray_ready = 1'b1;
    tick();

    fetch(1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch(1, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    fetch(1, 126, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch(2, 126, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    fetch(2, 125, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

    issue(5, 5, 1'b0, 1'b0, 1'b0);
    tick();
    bus.fetch_req = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    rdq.delete();
    wq.delete();
    mfirst = 1'b1;
    reads_model = 0;
    tick();
    chk("midrst_win", bus.win, 72'(0));
    chk("midrst_win_valid", 72'(bus.win_valid), 72'(0));
    chk("midrst_busy", 72'(bus.busy), 72'(0));
    chk("midrst_gray_req", 72'(bus.gray_req), 72'(0));
    reset = 1'b0;
    tick();
    tick();
    chk("midrst_no_late_capture", bus.win, 72'(0));
    fetch(5, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    cr = 5;
    cc = 6;
    for (int it = 0; it < 40; it++) begin
      mv = $urandom_range(0, 3);
      if (mv == 1 && cc < 126) begin
        cc = cc + 1;
        fetch(cr, cc, 1'b1, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      end else if (mv == 2 && cc > 1) begin
        cc = cc - 1;
        fetch(cr, cc, 1'b0, 1'b1,
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      end else if (mv == 3 && cr < 126) begin
        cr = cr + 1;
        fetch(cr, cc, 1'b0, 1'b0, 1'b1,
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      end else begin
        cr = $urandom_range(1, 126);
        cc = $urandom_range(1, 126);
        fetch(cr, cc, 1'b0, 1'b0, 1'b0, 1'b0,
              1'($urandom_range(0, 1)));
      end
    end

    fetch(126, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("final_done_pulse", 72'(bus.done), 72'(1));
    tick();
    chk("final_done_clear", 72'(bus.done), 72'(0));

    repeat (3) tick();
    chk("reads_all_seen", 72'(rdq.size()), 72'(0));
    chk("windows_all_seen", 72'(wq.size()), 72'(0));
`ifdef GFC_RDCNT_EN
    chk("rd_cnt_total", 72'(rd_cnt), 72'(reads_model));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
